ram_block_sdp: RTL and testbench
================================

RAM_BLOCK_SDP -- requirements
Module: ram_block_sdp

Interface
REQ-001 Parameter A_S, default 8: address width; depth is 2^A_S words.
REQ-002 Parameter M_S, default 4: number of byte-enable lanes per word.
REQ-003 Parameter D_S, default 32: data word width; D_S SHALL be an integer multiple of M_S, and lane width is D_S/M_S.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 wea  input  1: port A write enable.
REQ-007 bea  input  M_S: port A lane enables; bit i covers data bits [(i+1)*D_S/M_S-1 : i*D_S/M_S].
REQ-008 addra  input  A_S: port A (write) address.
REQ-009 dina  input  D_S: port A write data.
REQ-010 reb  input  1: port B read enable.
REQ-011 addrb  input  A_S: port B (read) address.
REQ-012 doutb  output  D_S: port B registered read data.
REQ-013 Storage SHALL be an unpacked array named data, indexed 0..2^A_S-1, of D_S-bit words, so benches can preload it hierarchically (inst.data[i] = value) at time zero.

Function
REQ-014 Simple dual-port: port A write-only, port B read-only, both on clk.
REQ-015 Write: at a clk edge with wea=1, for each lane i with bea[i]=1, data[addra] lane i SHALL take dina lane i; lanes with bea[i]=0 SHALL be unchanged.
REQ-016 wea=1 with bea=0 SHALL write nothing; wea=0 SHALL write nothing regardless of bea.
REQ-017 Read latency is 1 cycle: reb=1 at edge N SHALL make doutb equal data[addrb] sampled at edge N, valid from after edge N until the next read or reset.
REQ-018 With reb=0, doutb SHALL hold its last value indefinitely (downstream relies on stable payload while stalled).
REQ-019 doutb SHALL NOT depend combinationally on addrb, reb or any port A input.
REQ-020 Same-address collision (wea=1, reb=1, addra=addrb, same edge): read-first; doutb SHALL return the pre-write word, and the new word is visible on the next read.
REQ-021 Back-to-back reads (reb=1 every cycle) SHALL deliver one word per cycle, each one cycle after its address.
REQ-022 Addresses SHALL be A_S bits with no wrap or out-of-range handling; every code is a valid location.
REQ-023 Memory contents have no defined power-up value beyond any hierarchical preload.

Reset
REQ-024 With rst=1 at an edge, doutb SHALL become all zeros, and neither read nor write SHALL take effect at that edge.
REQ-025 rst SHALL NOT alter memory contents; preloaded or written data SHALL survive reset.
REQ-026 A reset asserted mid-operation (a read issued the previous cycle) SHALL clear doutb at the reset edge; the first reb=1 after rst deasserts SHALL behave per REQ-017.

Verification
REQ-027 Preload data[i]=32'h4000_0000+i for i=0..255; reb=1, addrb=8'h05 for one edge -> doutb=32'h4000_0005 after that edge and held while reb=0 for 10 cycles.
REQ-028 reb=1 with addrb stepping 0,1,2,3 on consecutive edges -> doutb reads 4000_0000, 4000_0001, 4000_0002, 4000_0003, each one cycle after its address.
REQ-029 Write addra=8'h10, dina=32'hAABB_CCDD, bea=4'b0101, wea=1 over preload 4000_0010, then read 8'h10 -> doutb=32'h40BB_00DD.
REQ-030 Same edge: wea=1, bea=4'hF, addra=addrb=8'h20, dina=32'h1234_5678, reb=1 -> doutb=32'h4000_0020; next read of 8'h20 -> 32'h1234_5678.
REQ-031 After reading 8'h05, assert rst one cycle -> doutb=0; after rst deasserts, read 8'h05 -> doutb=32'h4000_0005 (contents retained).
REQ-032 wea=1, bea=4'h0, addra=8'h30, dina=32'hFFFF_FFFF, then read 8'h30 -> doutb=32'h4000_0030 (no write).

Source files
------------

// File: rtl/ram_block_sdp.sv
// Simple dual-port RAM: port A writes with per-lane enables, port B reads with a
// registered output. Collisions are read-first, and reset clears only the read register.
module ram_block_sdp #(
  parameter int unsigned A_S = 8,  // address width
  parameter int unsigned M_S = 4,  // byte-enable lanes per word
  parameter int unsigned D_S = 32  // data word width
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wea,
  input  logic [M_S-1:0] bea,
  input  logic [A_S-1:0] addra,
  input  logic [D_S-1:0] dina,
  input  logic           reb,
  input  logic [A_S-1:0] addrb,
  output logic [D_S-1:0] doutb
);

  localparam int unsigned LaneW = D_S / M_S;
  localparam int unsigned Depth = 1 << A_S;

  // Catch a lane width that does not divide the word evenly at elaboration time.
  if ((D_S % M_S) != 0) begin : g_bad_lane_width
    $error("ram_block_sdp: D_S must be a multiple of M_S");
  end

  // Memory has no reset so that it maps onto block RAM and keeps its contents across rst.
  logic [D_S-1:0] data [0:Depth-1];

  logic [M_S-1:0] lane_we;
  logic [D_S-1:0] doutb_d, doutb_q;

  // Lane write strobes. Reset blocks writes at that edge.
  always_comb begin
    lane_we = '0;
    if (wea && !rst) begin
      lane_we = bea;
    end
  end

  // Read register next state. It holds when idle so a stalled consumer sees a stable payload.
  always_comb begin
    doutb_d = doutb_q;
    if (rst) begin
      doutb_d = '0;
    end else if (reb) begin
      doutb_d = data[addrb];
    end
  end

  // Per-lane memory write. The read above uses the old word, which makes collisions read-first.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < M_S; i++) begin
      if (lane_we[i]) begin
        data[addra][i*LaneW +: LaneW] <= dina[i*LaneW +: LaneW];
      end
    end
  end

  // Registered read data with synchronous clear.
  always_ff @(posedge clk) begin
    doutb_q <= doutb_d;
  end

  assign doutb = doutb_q;

endmodule

// File: tb/tb_ram_block_sdp.sv
// Randomized bench for ram_block_sdp. It checks the DUT against a word-level memory model,
// with directed cases for the documented scenarios.
module tb_ram_block_sdp;

  localparam int unsigned AW = 8;
  localparam int unsigned MW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wea;
  logic [MW-1:0] bea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          reb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] exp_dout;

  ram_block_sdp #(.A_S(AW), .M_S(MW), .D_S(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .wea   (wea),
    .bea   (bea),
    .addra (addra),
    .dina  (dina),
    .reb   (reb),
    .addrb (addrb),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // One clock: apply inputs, let the edge happen, update the model, then compare.
  task automatic step(input logic r, input logic we, input logic [MW-1:0] be,
                      input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic re, input logic [AW-1:0] ab, input string tag);
    logic [DW-1:0] mask;
    rst = r; wea = we; bea = be; addra = aa; dina = da; reb = re; addrb = ab;
    @(posedge clk);
    if (r) begin
      exp_dout = '0;
    end else begin
      if (re) exp_dout = mem[ab];  // old contents, so a collision returns the pre-write word
      if (we) begin
        mask = '0;
        for (int k = 0; k < int'(MW); k++) if (be[k]) mask |= 32'hFF << (8 * k);
        mem[aa] = (mem[aa] & ~mask) | (da & mask);
      end
    end
    #1;
    chk(tag, doutb, exp_dout);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 4'hF, AW'($urandom), $urandom, 1'b0, AW'($urandom), tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dut.data[i] = 32'h4000_0000 + i;
      mem[i]      = 32'h4000_0000 + i;
    end
    exp_dout = '0;
    rst = 1'b1; wea = 1'b0; bea = '0; addra = '0; dina = '0; reb = 1'b0; addrb = '0;

    // Reset state, with a read and a write requested during reset that must be ignored.
    step(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, "reset0");
    step(1'b1, 1'b1, 4'hF, 8'h07, 32'hDEAD_BEEF, 1'b1, 8'h07, "reset_rw");
    chk("reset_zero", doutb, 32'h0);

    // Single read, then hold while idle.
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h05, "rd05");
    chk("rd05_const", doutb, 32'h4000_0005);
    for (int i = 0; i < 10; i++) idle("hold");
    chk("hold_const", doutb, 32'h4000_0005);
    chk("no_write_in_reset", mem[7], 32'h4000_0007);
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h07, "rd07");
    chk("rd07_const", doutb, 32'h4000_0007);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, AW'(i), "b2b");
      chk("b2b_const", doutb, 32'h4000_0000 + i);
    end

    // Partial lane write.
    step(1'b0, 1'b1, 4'b0101, 8'h10, 32'hAABB_CCDD, 1'b0, 8'h00, "wr10");
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10, "rd10");
    chk("lane_merge", doutb, 32'h40BB_00DD);

    // Same-address collision: the read returns the old word.
    step(1'b0, 1'b1, 4'hF, 8'h20, 32'h1234_5678, 1'b1, 8'h20, "coll");
    chk("coll_old", doutb, 32'h4000_0020);
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h20, "coll_next");
    chk("coll_new", doutb, 32'h1234_5678);

    // Reset mid-operation keeps memory contents.
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h05, "pre_rst");
    step(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, "mid_rst");
    chk("mid_rst_zero", doutb, 32'h0);
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h05, "post_rst");
    chk("post_rst_const", doutb, 32'h4000_0005);

    // No lanes enabled, then write disabled with all lanes enabled.
    step(1'b0, 1'b1, 4'h0, 8'h30, 32'hFFFF_FFFF, 1'b0, 8'h00, "wr30_be0");
    step(1'b0, 1'b0, 4'hF, 8'h31, 32'hFFFF_FFFF, 1'b0, 8'h00, "wr31_we0");
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h30, "rd30");
    chk("be0_nowrite", doutb, 32'h4000_0030);
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h31, "rd31");
    chk("we0_nowrite", doutb, 32'h4000_0031);

    // Random traffic over a narrow address window so that collisions and rereads are common.
    for (int n = 0; n < 3000; n++) begin
      logic          r;
      logic [AW-1:0] aa, ab;
      r  = ($urandom_range(0, 40) == 0);
      aa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      ab = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, 15));
      step(r, 1'($urandom), MW'($urandom), aa, $urandom, 1'($urandom), ab, "rand");
    end

    // Final sweep: every location must match the model.
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, AW'(i), "sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
